pulse_train_generator: RTL

PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

---
 rtl/pulse_train_generator.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pulse_train_generator.sv
// Pulse-train generator: N high phases of H cycles separated by L-cycle low phases,
// followed by a one-cycle completion report. Define PULSE_TRAIN_REPORT_EN to drive write/report_out.
module pulse_train_generator #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16
) (
  input  logic         s_axi_aclk,
  input  logic         s_axi_aresetn,
  input  logic         cmd_valid,
  input  logic [63:0]  cmd_in,
  input  logic [63:0]  counter,
  output logic         output_sig,
  output logic         busy,
  output logic         write,
  output logic [127:0] report_out,
  output logic         busy_error
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam logic [3:0]            OP_START = 4'h1;
  localparam logic [3:0]            OP_STOP  = 4'h2;
  localparam logic [DATA_WIDTH-1:0] ONE_CNT  = DATA_WIDTH'(1'b1);

  // Phase counters are loaded with (length - 1); a zero length behaves as one cycle.
  function automatic logic [PHASE_WIDTH-1:0] phase_load(input logic [PHASE_WIDTH-1:0] len);
    logic [PHASE_WIDTH-1:0] res;
    if (len == {PHASE_WIDTH{1'b0}}) begin
      res = {PHASE_WIDTH{1'b0}};
    end else begin
      res = len - PHASE_WIDTH'(1'b1);
    end
    return res;
  endfunction

  state_e                  state_q, state_d;
  logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
  logic [DATA_WIDTH-1:0]   pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0]   n_q, n_d;
  logic [PHASE_WIDTH-1:0]  h_q, h_d;
  logic [PHASE_WIDTH-1:0]  l_q, l_d;
  logic                    out_q, out_d;
  logic                    busy_q, busy_d;
  logic                    berr_q, berr_d;
  logic                    write_q, write_d;

  logic                    is_start_s;
  logic                    is_stop_s;
  logic [DATA_WIDTH-1:0]   cmd_n_s;
  logic [PHASE_WIDTH-1:0]  cmd_h_s;
  logic [PHASE_WIDTH-1:0]  cmd_l_s;
  logic                    unused_cmd_s;

  assign is_start_s   = cmd_valid && (cmd_in[63:60] == OP_START);
  assign is_stop_s    = cmd_valid && (cmd_in[63:60] == OP_STOP);
  assign cmd_n_s      = cmd_in[DATA_WIDTH-1:0];
  assign cmd_h_s      = cmd_in[16 +: PHASE_WIDTH];
  assign cmd_l_s      = cmd_in[32 +: PHASE_WIDTH];
  assign unused_cmd_s = ^cmd_in;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    n_d     = n_q;
    h_d     = h_q;
    l_d     = l_q;
    berr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_start_s) begin
          n_d = cmd_n_s;
          h_d = cmd_h_s;
          l_d = cmd_l_s;
          if (cmd_n_s == {DATA_WIDTH{1'b0}}) begin
            state_d = ST_REPORT;
            pulse_d = {DATA_WIDTH{1'b0}};
          end else begin
            state_d = ST_HIGH;
            pulse_d = ONE_CNT;
            phase_d = phase_load(cmd_h_s);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        berr_d = is_start_s;
        if (is_stop_s) begin
          state_d = ST_REPORT;
        end else if (phase_q == {PHASE_WIDTH{1'b0}}) begin
          // The last high phase goes straight to REPORT with no trailing low phase.
          if (pulse_q == n_q) begin
            state_d = ST_REPORT;
          end else begin
            state_d = ST_LOW;
            phase_d = phase_load(l_q);
          end
        end else begin
          phase_d = phase_q - PHASE_WIDTH'(1'b1);
        end
      end
      ST_LOW: begin
        berr_d = is_start_s;
        if (is_stop_s) begin
          state_d = ST_REPORT;
        end else if (phase_q == {PHASE_WIDTH{1'b0}}) begin
          state_d = ST_HIGH;
          pulse_d = pulse_q + ONE_CNT;
          phase_d = phase_load(h_q);
        end else begin
          phase_d = phase_q - PHASE_WIDTH'(1'b1);
        end
      end
      ST_REPORT: begin
        berr_d  = is_start_s;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
`ifdef PULSE_TRAIN_REPORT_EN
    write_d = (state_d == ST_REPORT);
`else
    write_d = 1'b0;
`endif
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q <= ST_IDLE;
      phase_q <= {PHASE_WIDTH{1'b0}};
      pulse_q <= {DATA_WIDTH{1'b0}};
      n_q     <= {DATA_WIDTH{1'b0}};
      h_q     <= {PHASE_WIDTH{1'b0}};
      l_q     <= {PHASE_WIDTH{1'b0}};
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      berr_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      n_q     <= n_d;
      h_q     <= h_d;
      l_q     <= l_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      berr_q  <= berr_d;
      write_q <= write_d;
    end
  end

  assign output_sig = out_q;
  assign busy       = busy_q;
  assign busy_error = berr_q;
  assign write      = write_q;

`ifdef PULSE_TRAIN_REPORT_EN
  logic [63:0]  cnt_ext_s;
  logic [127:0] report_s;

  assign cnt_ext_s = 64'(pulse_q);

  // The timestamp must be the counter value of the REPORT cycle itself, so it is gated, not latched.
  always_comb begin
    report_s = {128{1'b0}};
    if (write_q) begin
      report_s = {counter, cnt_ext_s};
    end else begin
      report_s = {128{1'b0}};
    end
  end

  assign report_out = report_s;
`else
  logic unused_counter_s;

  assign unused_counter_s = ^counter;
  assign report_out       = {128{1'b0}};
`endif

endmodule
